// File: rtl/melody_player.sv
// Note-table driven square-wave player: fetch an entry, sound it for its
// duration, insert a short silent gap, then advance, loop or finish.
module melody_player #(
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = 7,
  parameter int HALF_W     = 20,
  parameter int DUR_W      = 4,
  parameter int BEAT_TICKS = 2_500_000,
  parameter int GAP_TICKS  = 250_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [HALF_W+DUR_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]       last_addr,
  input  logic                    loop_en,
  input  logic                    start,
  input  logic                    stop,
  output logic                    buzzer_pin,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       cur_index
);

  localparam int TONE_MAX = (2**DUR_W - 1) * BEAT_TICKS;
  localparam int CNT_MAX  = (TONE_MAX > GAP_TICKS) ? TONE_MAX : GAP_TICKS;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    TONE,
    GAP
  } state_t;

  state_t state, state_d;

  logic [HALF_W+DUR_W-1:0] mem [DEPTH];

  logic [HALF_W+DUR_W-1:0] rd;
  logic [HALF_W-1:0]       rd_half;
  logic [DUR_W-1:0]        rd_dur;

  logic [HALF_W-1:0] half_q, half_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [HALF_W-1:0] hcnt, hcnt_d;
  logic [ADDR_W-1:0] idx_d, idx_inc;
  logic [CNT_W-1:0]  tone_last;
  logic              pin_d, done_d;

  // Table has no reset so a song survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH))
      mem[wr_addr] <= wr_data;
  end

  assign rd      = mem[cur_index];
  assign rd_half = rd[HALF_W+DUR_W-1:DUR_W];
  assign rd_dur  = rd[DUR_W-1:0];

  assign tone_last = CNT_W'(dur_q) * CNT_W'(BEAT_TICKS)
                   - CNT_W'(1);

  assign idx_inc = (cur_index == ADDR_W'(DEPTH - 1))
                 ? '0 : cur_index + ADDR_W'(1);

  assign busy = (state != IDLE);

  always_comb begin
    state_d = state;
    idx_d   = cur_index;
    cnt_d   = cnt;
    hcnt_d  = hcnt;
    pin_d   = buzzer_pin;
    done_d  = 1'b0;
    half_d  = half_q;
    dur_d   = dur_q;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
      pin_d   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_d = FETCH;
            idx_d   = '0;
            cnt_d   = '0;
            hcnt_d  = '0;
            pin_d   = 1'b0;
          end
        end
        FETCH: begin
          half_d = rd_half;
          dur_d  = rd_dur;
          cnt_d  = '0;
          hcnt_d = '0;
          pin_d  = 1'b0;
          if (rd_dur == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = TONE;
          end
        end
        TONE: begin
          if (cnt == tone_last) begin
            state_d = GAP;
            cnt_d   = '0;
            hcnt_d  = '0;
            pin_d   = 1'b0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
            if (half_q == '0) begin
              pin_d = 1'b0;
            end else if (hcnt == half_q - HALF_W'(1)) begin
              hcnt_d = '0;
              pin_d  = ~buzzer_pin;
            end else begin
              hcnt_d = hcnt + HALF_W'(1);
            end
          end
        end
        GAP: begin
          pin_d = 1'b0;
          if (cnt == GAP_LAST) begin
            cnt_d = '0;
            if (cur_index != last_addr) begin
              idx_d   = idx_inc;
              state_d = FETCH;
            end else if (loop_en) begin
              idx_d   = '0;
              state_d = FETCH;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_index  <= '0;
      cnt        <= '0;
      hcnt       <= '0;
      half_q     <= '0;
      dur_q      <= '0;
      buzzer_pin <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      cur_index  <= idx_d;
      cnt        <= cnt_d;
      hcnt       <= hcnt_d;
      half_q     <= half_d;
      dur_q      <= dur_d;
      buzzer_pin <= pin_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_melody_player.sv
// Randomized bench for melody_player: a per-cycle trace built from the
// note-table rules is compared against {busy, done, pin, cur_index}.
module tb_melody_player;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int HALF_W = 20;
  localparam int DUR_W  = 4;
  localparam int BT     = 10;
  localparam int GT     = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    wr_en = 1'b0;
  logic [ADDR_W-1:0]       wr_addr = '0;
  logic [HALF_W+DUR_W-1:0] wr_data = '0;
  logic [ADDR_W-1:0]       last_addr = '0;
  logic                    loop_en = 1'b0;
  logic                    start = 1'b0;
  logic                    stop = 1'b0;
  logic                    buzzer_pin;
  logic                    busy;
  logic                    done;
  logic [ADDR_W-1:0]       cur_index;

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned tb_half [DEPTH];
  int unsigned tb_dur  [DEPTH];

  logic [5:0] exp_q [$];

  melody_player #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .HALF_W(HALF_W), .DUR_W(DUR_W),
    .BEAT_TICKS(BT), .GAP_TICKS(GT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .last_addr(last_addr),
    .loop_en(loop_en), .start(start),
    .stop(stop), .buzzer_pin(buzzer_pin),
    .busy(busy), .done(done),
    .cur_index(cur_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] obs();
    return {busy, done, buzzer_pin, cur_index};
  endfunction

  function automatic logic [5:0] tup(input bit b, input bit d,
                                     input bit p, input int i);
    logic [2:0] ix;
    ix = 3'(i);
    return {b, d, p, ix};
  endfunction

  task automatic wr(input int a, input int unsigned h,
                    input int unsigned d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = {20'(h), 4'(d)};
    @(negedge clk);
    wr_en = 1'b0;
    tb_half[a] = h;
    tb_dur[a]  = d;
  endtask

  // Expected per-cycle trace from the first cycle after start onward.
  task automatic model(input int cap);
    int i;
    bit fin;
    i = 0;
    fin = 0;
    exp_q.delete();
    while (!fin && exp_q.size() < cap) begin
      exp_q.push_back(tup(1, 0, 0, i));
      if (tb_dur[i] == 0) begin
        fin = 1;
      end else begin
        for (int k = 0; k < int'(tb_dur[i]) * BT; k++) begin
          bit p;
          p = (tb_half[i] == 0) ? 1'b0
            : 1'((k / int'(tb_half[i])) % 2);
          exp_q.push_back(tup(1, 0, p, i));
        end
        for (int g = 0; g < GT; g++)
          exp_q.push_back(tup(1, 0, 0, i));
        if (i == int'(last_addr)) begin
          if (loop_en) i = 0;
          else fin = 1;
        end else begin
          i = (i + 1) % DEPTH;
        end
      end
    end
    if (fin) begin
      exp_q.push_back(tup(0, 1, 0, i));
      exp_q.push_back(tup(0, 0, 0, i));
    end
  endtask

  task automatic play(input string tag, input int stop_at,
                      input int cap, input bit wr0,
                      input int unsigned wh,
                      input int unsigned wd);
    int sa;
    logic [2:0] ix;
    model(cap);
    sa = stop_at;
    if (sa >= exp_q.size()) sa = -1;
    if (sa >= 0 && exp_q[sa][5] == 1'b0) sa = -1;
    if (sa < 0 && exp_q[exp_q.size()-1][5]) sa = exp_q.size() - 1;
    if (sa >= 0) begin
      ix = exp_q[sa][2:0];
      while (exp_q.size() > sa + 1) void'(exp_q.pop_back());
      exp_q.push_back({3'b000, ix});
      exp_q.push_back({3'b000, ix});
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check($sformatf("%s[%0d]", tag, k), 32'(obs()), 32'(exp_q[k]));
      stop = (k == sa);
      if (wr0 && k == 0) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = {20'(wh), 4'(wd)};
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      if (wr0 && k == 0) begin
        tb_half[0] = wh;
        tb_dur[0]  = wd;
      end
    end
    stop  = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tb_half[i] = 0;
      tb_dur[i]  = 0;
    end
    #12;
    check("reset", 32'(obs()), 32'(tup(0, 0, 0, 0)));
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) wr(i, 0, 0);

    wr(0, 3, 2);
    last_addr = 0;
    loop_en   = 1'b0;
    play("single", -1, 400, 0, 0, 0);

    wr(0, 0, 1);
    play("rest", -1, 400, 0, 0, 0);

    begin
      int l0, l1;
      wr(0, 2, 1);
      wr(1, 1, 2);
      l0 = 1 + 1 * BT + GT;
      l1 = 1 + 2 * BT + GT;
      last_addr = 1;
      loop_en   = 1'b1;
      play("loop", l0 + l1 + l0 + 5, 400, 0, 0, 0);
    end

    wr(0, 1, 1);
    wr(1, 2, 1);
    wr(2, 3, 0);
    wr(3, 1, 2);
    wr(4, 2, 2);
    wr(5, 3, 2);
    last_addr = 5;
    loop_en   = 1'b0;
    play("marker", -1, 400, 0, 0, 0);

    wr(0, 2, 1);
    last_addr = 0;
    play("wrfetch", -1, 400, 1, 5, 3);
    play("wrnew", -1, 400, 0, 0, 0);

    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        int unsigned d;
        d = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 3);
        wr(i, $urandom_range(0, 4), d);
      end
      last_addr = 3'($urandom_range(0, DEPTH - 1));
      loop_en   = 1'($urandom_range(0, 1));
      play($sformatf("rnd%0d", it),
           ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 200)) : -1,
           300, 0, 0, 0);
    end

    wr(0, 1, 3);
    last_addr = 0;
    loop_en   = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", 32'(obs()), 32'(tup(0, 0, 0, 0)));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_autostart", 32'(obs()), 32'(tup(0, 0, 0, 0)));
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop", 32'(obs()), 32'(tup(0, 0, 0, 0)));
    @(negedge clk);
    check("start_stop2", 32'(obs()), 32'(tup(0, 0, 0, 0)));
    play("retained", -1, 400, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
